serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 1..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock; one clock domain only.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; sampled on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; sampled on the accepting edge.
REQ-007 SHALL have port bin  input  1  borrow-in; sampled on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; d and borrow are valid and new.
REQ-010 SHALL have port d  output  WIDTH  difference, computed as a - b - bin.
REQ-011 SHALL have port borrow  output  1  borrow-out from the MSB stage.

Function
REQ-012 SHALL have a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL accept start=1 in IDLE at edge k, which:
- latches a, b and bin into internal shift and borrow registers;
- clears the bit counter;
- enters RUN;
- sets busy=1 from edge k.
REQ-014 SHALL process exactly one bit per clock in RUN, LSB first, through a single full-subtractor cell:
- diff = a_i ^ b_i ^ br;
- br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-015 SHALL shift each diff bit into the result register from the MSB side, so that after WIDTH bits the result is aligned with bit 0 = LSB.
REQ-016 SHALL complete the last bit at edge k+WIDTH. At that edge it:
- updates d and borrow;
- enters DONE with done=1 and busy=0.
REQ-017 SHALL return from DONE to IDLE on the next edge, with done=0, so that done is exactly one cycle wide.
REQ-018 SHALL allow a new start to be accepted in IDLE only. The earliest back-to-back acceptance is edge k+WIDTH+2.
REQ-019 SHALL ignore start while in RUN or DONE, with no effect on the operation in progress.
REQ-020 SHALL ignore changes on a, b and bin after the accepting edge.
REQ-021 SHALL hold d and borrow stable between completions; they change only at a completion edge or at reset.
REQ-022 SHALL give a result equal to (a - b - bin) mod 2^WIDTH, with borrow=1 iff a < b + bin (unsigned).
REQ-023 SHALL, for WIDTH=1, produce d and borrow identical to the single-bit full-subtractor truth table.

Reset
REQ-024 SHALL drive the following on rst=1, immediately and regardless of clk:
- FSM to IDLE;
- busy=0, done=0, d=0, borrow=0;
- counter, shift registers and borrow register to 0.
REQ-025 SHALL abort an operation in progress when rst is asserted during RUN, with no done pulse and no partial result visible on d.
REQ-026 SHALL leave start ignored while rst=1. The first acceptance is possible at the first rising edge after rst is deasserted.

Configuration
REQ-027 SHALL honour macro SERIAL_SUB_SATURATE_EN. When it is defined:
- a completion with final borrow=1 forces d to all zeros;
- borrow still reports 1.
REQ-028 SHALL, when SERIAL_SUB_SATURATE_EN is undefined, output the wrap-around result of REQ-022 with no clamping logic present.

Verification
REQ-029 SHALL pass, with WIDTH=8: a=0x35, b=0x12, bin=0, start at edge k -> busy 1 for 8 cycles; done=1 after edge k+8; d=0x23, borrow=0.
REQ-030 SHALL pass, with WIDTH=8: a=0x00, b=0x01, bin=0 -> borrow=1; d=0xFF (wrap build), d=0x00 (SERIAL_SUB_SATURATE_EN build).
REQ-031 SHALL pass, with WIDTH=8: a=0x10, b=0x0F, bin=1 -> d=0x00, borrow=0. Then a=0xFF, b=0xFF, bin=1 -> d=0xFF (wrap build), borrow=1.
REQ-032 SHALL pass, with WIDTH=8: accept a=0x80, b=0x01; pulse start again with a=0x00 at RUN cycle 3 -> single done with d=0x7F; a second start after DONE is accepted.
REQ-033 SHALL pass, with WIDTH=8: assert rst at RUN cycle 4, then release -> busy=0, d=0, borrow=0 immediately, no done pulse; next operation 0x09-0x03 gives d=0x06.
REQ-034 SHALL pass, with WIDTH=1: all 8 combinations of a, b, bin -> (d,borrow) = 00, 11, 11, 01, 10, 00, 00, 11 in order abc=000..111.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes d = a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell controlled by an IDLE/RUN/DONE FSM.
// Optional feature macro: SERIAL_SUB_SATURATE_EN clamps d to zero whenever the
// final borrow is set (borrow itself still reports 1).
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   busy_next;
  logic   done_next;

  // Operand shift registers, running borrow, partial result and bit counter
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CNT_W-1:0] cnt;

  // Full-subtractor cell and datapath control
  logic             a_bit;
  logic             b_bit;
  logic             diff_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] d_final;
  logic             last_bit;
  logic             load;
  logic             step;
  logic             finish;

  // Single full-subtractor stage operating on the current LSBs
  always_comb begin
    a_bit     = a_sh[0];
    b_bit     = b_sh[0];
    diff_bit  = a_bit ^ b_bit ^ br;
    br_nxt    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    // New diff bit enters from the MSB side so the result ends LSB-aligned
    res_shift = (res >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));
    last_bit  = (cnt == CNT_W'(WIDTH - 1));
  end

  // Datapath strobes derived from the current state
  always_comb begin
    load   = (state == IDLE) && start;
    step   = (state == RUN);
    finish = step && last_bit;
  end

`ifdef SERIAL_SUB_SATURATE_EN
  // Clamp to zero when the subtraction underflows
  always_comb begin
    d_final = br_nxt ? '0 : res_shift;
  end
`else
  // Plain wrap-around result
  always_comb begin
    d_final = res_shift;
  end
`endif

  // FSM state and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next = state;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          busy_next  = 1'b1;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          busy_next  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture and per-bit shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      br   <= 1'b0;
      res  <= '0;
      cnt  <= '0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      br   <= bin;
      res  <= '0;
      cnt  <= '0;
    end else if (step) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br   <= br_nxt;
      res  <= res_shift;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // Result outputs update only on the completing edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d      <= '0;
      borrow <= 1'b0;
    end else if (finish) begin
      d      <= d_final;
      borrow <= br_nxt;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances,
// directed tables, hand-written timing sequences and random operations
// compared against an arithmetic reference model.
module tb_serial_subtractor;

`ifdef SERIAL_SUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic       start8, bin8, busy8, done8, borrow8;
  logic [7:0] a8, b8, d8;
  logic       start1, bin1, busy1, done1, borrow1;
  logic [0:0] a1, b1, d1;

  int total  = 0;
  int passed = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .d(d1), .borrow(borrow1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       br;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic, returns {borrow, d}
  function automatic logic [64:0] ref_sub(input longint unsigned ra, input longint unsigned rb,
                                          input bit rbin, input int w);
    longint unsigned mask;
    logic [63:0] rd;
    bit rbr;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    rd   = 64'(ra - rb - 64'(rbin)) & mask;
    rbr  = (ra < (rb + 64'(rbin)));
    if (SAT && rbr) rd = '0;
    return {rbr, rd};
  endfunction

  // One WIDTH=8 operation: checks busy window, latency, result and done width
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin, input string nm);
    int n;
    bit seen, busy_ok;
    logic [64:0] e;
    e = ref_sub(64'(ta), 64'(tb), tbin, 8);
    @(negedge clk);
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk({nm, "_busy_on"}, 64'(busy8), 64'd1);
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    n = 0; seen = 0; busy_ok = 1;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done8) seen = 1;
      else if (!busy8) busy_ok = 0;
    end
    chk({nm, "_latency"}, 64'(n), 64'd8);
    chk({nm, "_busy_held"}, 64'(busy_ok), 64'd1);
    chk({nm, "_d"}, 64'(d8), 64'(e[7:0]));
    chk({nm, "_borrow"}, 64'(borrow8), 64'(e[64]));
    chk({nm, "_busy_at_done"}, 64'(busy8), 64'd0);
    @(posedge clk); #1;
    chk({nm, "_done_one_cycle"}, 64'(done8), 64'd0);
  endtask

  // One WIDTH=1 operation: completes one edge after acceptance
  task automatic op1(input logic ta, input logic tb, input logic tbin,
                     input logic ed, input logic ebr, input string nm);
    @(negedge clk);
    a1 = ta; b1 = tb; bin1 = tbin; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk({nm, "_busy"}, 64'(busy1), 64'd1);
    @(posedge clk); #1;
    chk({nm, "_done"}, 64'(done1), 64'd1);
    chk({nm, "_dbr"}, 64'({d1, borrow1}), 64'({ed, ebr}));
    @(posedge clk); #1;
  endtask

  vec_t vt8[4];
  logic [1:0] tt1[8];

  initial begin
    int n, dones;
    logic [7:0] d_hold;
    logic [64:0] e;

    rst = 1'b1;
    start8 = 1'b1; a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;

    // Reset state, with start held high across an edge
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_outs8", 64'({done8, d8, borrow8}), 64'd0);
    chk("rst_outs1", 64'({busy1, done1, d1, borrow1}), 64'd0);
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;

    // Directed WIDTH=8 vectors
    vt8[0] = '{a: 8'h35, b: 8'h12, bin: 1'b0, d: 8'h23, br: 1'b0};
    vt8[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: SAT ? 8'h00 : 8'hFF, br: 1'b1};
    vt8[2] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, br: 1'b0};
    vt8[3] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, d: SAT ? 8'h00 : 8'hFF, br: 1'b1};
    for (int i = 0; i < 4; i++) begin
      op8(vt8[i].a, vt8[i].b, vt8[i].bin, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_table_d", i), 64'({d8, borrow8}), 64'({vt8[i].d, vt8[i].br}));
    end

    // WIDTH=1 truth table, abc = 000..111 -> (d, borrow)
    tt1 = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      logic [1:0] ex;
      abc = 3'(i);
      ex  = tt1[i];
      if (SAT && ex[0]) ex[1] = 1'b0;
      op1(abc[2], abc[1], abc[0], ex[1], ex[0], $sformatf("w1_%0d", i));
    end

    // Start pulse mid-RUN is ignored; back-to-back start held from DONE
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h22;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign_latency", 64'(n), 64'd4);
    chk("ign_d", 64'(d8), 64'h7F);
    chk("ign_borrow", 64'(borrow8), 64'd0);
    start8 = 1'b1; a8 = 8'h44; b8 = 8'h04; bin8 = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done_edge_ignored", 64'({busy8, done8}), 64'd0);
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("b2b_accept", 64'(busy8), 64'd1);
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_latency", 64'(n), 64'd8);
    chk("b2b_d", 64'(d8), 64'h40);

    // Outputs hold between completions while inputs wander
    d_hold = d8;
    repeat (5) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
    #1;
    chk("hold_d", 64'({d8, borrow8}), 64'({d_hold, 1'b0}));

    // Reset during RUN aborts with no done pulse
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_outs", 64'({done8, d8, borrow8}), 64'd0);
    start8 = 1'b1;
    @(posedge clk); #1;
    chk("abort_start_ignored", 64'(busy8), 64'd0);
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_d_zero", 64'(d8), 64'd0);
    op8(8'h09, 8'h03, 1'b0, "post_abort");
    chk("post_abort_val", 64'(d8), 64'h06);

    // Random operations against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra, rb;
      logic rbin;
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (i % 5 == 0) rb = ra;
      op8(ra, rb, rbin, $sformatf("rnd%0d", i));
      e = ref_sub(64'(ra), 64'(rb), rbin, 8);
      chk($sformatf("rnd%0d_model", i), 64'({borrow8, d8}), 64'(e[8:0] | (65'(e[64]) << 8)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
